// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state codes and address-field width helpers for rv_cache
package cache_pkg;

    typedef logic [1:0] cache_state_t;

    localparam cache_state_t ST_IDLE       = 2'd0;
    localparam cache_state_t ST_REFILL     = 2'd1;
    localparam cache_state_t ST_WRITE      = 2'd2;
    localparam cache_state_t ST_INVAL_PEND = 2'd3;

    function automatic int off_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int word_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int addr_w, input int data_w,
                                    input int line_words, input int sets);
        return addr_w - off_bits(data_w) - word_bits(line_words) - idx_bits(sets);
    endfunction

    // A zero-bit field (LINE_WORDS=1) still needs a one-bit signal to carry it.
    function automatic int field_w(input int bits);
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// rtl/cache_line_array.sv - valid/tag/data storage, async read, word write, tag set, global clear
module cache_line_array
    import cache_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16,
    parameter int TAG_W      = 24,
    parameter int IW         = 4,
    parameter int WW         = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IW-1:0]     rd_idx_i,
    input  logic [WW-1:0]     rd_word_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [IW-1:0]     wr_idx_i,
    input  logic [WW-1:0]     wr_word_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              tag_we_i,
    input  logic [TAG_W-1:0]  tag_data_i,
    input  logic              clr_all_i
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS][LINE_WORDS];

    // Clear wins over a tag set so an invalidate can never be lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (clr_all_i) begin
            valid_q <= '0;
        end else if (tag_we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we_i) begin
            tag_q[wr_idx_i] <= tag_data_i;
        end
        if (wr_en_i) begin
            data_q[wr_idx_i][wr_word_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_word_i];

endmodule

// File: rtl/rv_cache.sv
// rtl/rv_cache.sv - direct-mapped write-through cache with burst refill; RV_CACHE_STATS_EN adds hit/miss counters
module rv_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16
) (
`ifdef RV_CACHE_STATS_EN
    output logic [31:0]       o_hit_cnt,
    output logic [31:0]       o_miss_cnt,
`endif
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ready,
    input  logic              i_inval,
    output logic              o_busy,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int OFF_B = off_bits(DATA_W);
    localparam int WORD_B = word_bits(LINE_WORDS);
    localparam int IDX_B = idx_bits(SETS);
    localparam int TAG_W = tag_bits(ADDR_W, DATA_W, LINE_WORDS, SETS);
    localparam int WW = field_w(WORD_B);
    localparam int IW = field_w(IDX_B);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ADDR_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] IDX_MASK   = ADDR_W'(SETS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK  = ADDR_W'(LINE_WORDS * (DATA_W / 8) - 1);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);
    localparam logic [WW-1:0]     LAST_WORD  = WW'(LINE_WORDS - 1);

    cache_state_t      state_q, state_d;
    logic [WW-1:0]     k_q, k_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              inval_q, inval_d;

    logic [WW-1:0]     req_word;
    logic [IW-1:0]     req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              rd_valid, tag_match, rd_hit;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              arr_we, tag_we, clr_all;
    logic [WW-1:0]     arr_word;
    logic [DATA_W-1:0] arr_data;

    assign req_word = WW'((i_addr >> OFF_B) & WORD_MASK);
    assign req_idx  = IW'((i_addr >> (OFF_B + WORD_B)) & IDX_MASK);
    assign req_tag  = TAG_W'(i_addr >> (OFF_B + WORD_B + IDX_B));

    cache_line_array #(
        .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS),
        .TAG_W(TAG_W), .IW(IW), .WW(WW)
    ) u_lines (
        .clk(clk), .rst(rst),
        .rd_idx_i(req_idx), .rd_word_i(req_word),
        .rd_valid_o(rd_valid), .rd_tag_o(rd_tag), .rd_data_o(rd_data),
        .wr_en_i(arr_we), .wr_idx_i(req_idx), .wr_word_i(arr_word), .wr_data_i(arr_data),
        .tag_we_i(tag_we), .tag_data_i(req_tag), .clr_all_i(clr_all)
    );

    // An invalidate in the same cycle forces the access down the miss path.
    assign tag_match = rd_valid && (rd_tag == req_tag);
    assign rd_hit    = (state_q == ST_IDLE) && i_req && !i_we && tag_match && !i_inval;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        inval_d     = inval_q;
        arr_we      = 1'b0;
        arr_word    = req_word;
        arr_data    = mem_wdata_q;
        tag_we      = 1'b0;
        clr_all     = 1'b0;
        o_ready     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_ready = rd_hit;
                clr_all = i_inval;
                if (i_req && i_we) begin
                    state_d     = ST_WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = i_wdata;
                end else if (i_req && !rd_hit) begin
                    state_d    = ST_REFILL;
                    k_d        = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_addr & ~LINE_MASK;
                end
            end
            ST_REFILL: begin
                inval_d = inval_q || i_inval;
                if (i_mem_ack) begin
                    arr_we   = 1'b1;
                    arr_word = k_q;
                    arr_data = i_mem_rdata;
                    if (k_q == LAST_WORD) begin
                        tag_we    = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = (inval_q || i_inval) ? ST_INVAL_PEND : ST_IDLE;
                    end else begin
                        k_d        = k_q + WW'(1);
                        mem_addr_d = mem_addr_q + WORD_BYTES;
                    end
                end
            end
            ST_WRITE: begin
                inval_d = inval_q || i_inval;
                if (i_mem_ack) begin
                    o_ready   = 1'b1;
                    arr_we    = tag_match;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = (inval_q || i_inval) ? ST_INVAL_PEND : ST_IDLE;
                end
            end
            default: begin
                clr_all = 1'b1;
                inval_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            inval_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            inval_q     <= inval_d;
        end
    end

    assign o_rdata     = rd_hit ? rd_data : '0;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;

`ifdef RV_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        refill_start;

    assign refill_start = (state_q == ST_IDLE) && i_req && !i_we && !rd_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_q + {31'd0, rd_hit};
            miss_cnt_q <= miss_cnt_q + {31'd0, refill_start};
        end
    end

    assign o_hit_cnt  = hit_cnt_q;
    assign o_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_rv_cache.sv
// tb/tb_rv_cache.sv - directed and random checks of rv_cache against a line-residency and memory model
module tb_rv_cache;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req = 1'b0, i_we = 1'b0, i_inval = 1'b0, i_mem_ack = 1'b0;
    logic [31:0] i_addr = '0, i_wdata = '0, i_mem_rdata = '0;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic        o_ready, o_busy, o_mem_req, o_mem_we;
`ifdef RV_CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic [31:0] mem [int];
    int resident [16];
    int exp_hits = 0;
    int exp_misses = 0;
    int pool [7] = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h040, 32'h140, 32'h1040};

    rv_cache dut (
        .clk(clk),
`ifdef RV_CACHE_STATS_EN
        .o_hit_cnt(hit_cnt),
        .o_miss_cnt(miss_cnt),
`endif
        .rst(rst_n),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_rdata(o_rdata), .o_ready(o_ready), .i_inval(i_inval), .o_busy(o_busy),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic clear_model();
        foreach (resident[i]) resident[i] = -1;
    endtask

    // One core access; the bench plays memory, acking each request after 'delay' wait cycles.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int delay, input int inval_word);
        int idx, base, acks_exp, cyc_exp, words, wait_cnt, cycles;
        bit hit_exp, acked, done, inval_done;
        logic [31:0] rdata_seen;
        idx = int'((addr >> 4) & 32'hF);
        base = int'(addr & ~32'hF);
        hit_exp = (resident[idx] == base);
        if (we) begin
            acks_exp = 1;
            cyc_exp = 2 + delay;
        end else if (inval_word >= 0) begin
            acks_exp = 2 * LW;
            cyc_exp = 2 * (LW * (delay + 1) + 2);
            exp_misses += 2;
            exp_hits++;
        end else if (hit_exp) begin
            acks_exp = 0;
            cyc_exp = 1;
            exp_hits++;
        end else begin
            acks_exp = LW;
            cyc_exp = LW * (delay + 1) + 2;
            exp_misses++;
            exp_hits++;
        end
        words = 0; wait_cnt = 0; cycles = 0;
        acked = 0; done = 0; inval_done = 0; rdata_seen = '0;
        i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (o_mem_req) begin
                if (we) begin
                    check("wr_addr", o_mem_addr, addr);
                    check("wr_we", {31'd0, o_mem_we}, 32'd1);
                    check("wr_data", o_mem_wdata, wdata);
                end else begin
                    check("refill_addr", o_mem_addr, 32'(base + 4 * (words % LW)));
                    check("refill_we", {31'd0, o_mem_we}, 32'd0);
                end
                if (inval_word == words && !inval_done) begin
                    i_inval = 1'b1;
                    inval_done = 1;
                end
                if (wait_cnt == delay) begin
                    i_mem_ack = 1'b1;
                    i_mem_rdata = memval(o_mem_addr);
                    acked = 1;
                end else begin
                    wait_cnt++;
                end
            end
            #1;
            cycles++;
            if (o_ready) begin
                done = 1;
                rdata_seen = o_rdata;
            end
            @(posedge clk);
            #1;
            if (acked) begin
                if (we) mem[int'(addr)] = wdata;
                words++;
                wait_cnt = 0;
                acked = 0;
            end
            i_mem_ack = 1'b0;
            i_inval = 1'b0;
        end
        i_req = 1'b0;
        i_we = 1'b0;
        check("done", {31'd0, done}, 32'd1);
        check("mem_acks", 32'(words), 32'(acks_exp));
        check("latency", 32'(cycles), 32'(cyc_exp));
        if (!we) begin
            check("rdata", rdata_seen, memval(addr));
            if (inval_word >= 0) clear_model();
            resident[idx] = base;
        end
    endtask

    task automatic inval_idle();
        i_inval = 1'b1;
        @(posedge clk);
        #1;
        i_inval = 1'b0;
        clear_model();
        check("inval_busy", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        int op;
        logic [31:0] a;
        clear_model();
        for (int i = 0; i < LW; i++) mem[32'h100 + 4 * i] = 32'hA0 + i;

        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, o_mem_we}, 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        check("rst_mem_wdata", o_mem_wdata, 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        access(1'b0, 32'h100, 32'h0, 1, -1);
        check("cold_word0", memval(32'h100), 32'hA0);
        access(1'b0, 32'h108, 32'h0, 0, -1);
        access(1'b0, 32'h200, 32'h0, 0, -1);
        access(1'b0, 32'h100, 32'h0, 0, -1);
        access(1'b1, 32'h104, 32'h55, 3, -1);
        access(1'b0, 32'h104, 32'h0, 0, -1);
        check("write_hit_data", memval(32'h104), 32'h55);
        access(1'b1, 32'h300, 32'h77, 1, -1);
        access(1'b0, 32'h300, 32'h0, 0, -1);

        inval_idle();
        access(1'b0, 32'h100, 32'h0, 0, 1);
        access(1'b0, 32'h10C, 32'h0, 0, -1);

        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h500;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_req", {31'd0, o_mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", {31'd0, o_mem_req}, 32'd0);
        check("async_rst_busy", {31'd0, o_busy}, 32'd0);
        check("async_rst_addr", o_mem_addr, 32'd0);
        i_req = 1'b0;
        clear_model();
        exp_hits = 0;
        exp_misses = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(1'b0, 32'h100, 32'h0, 0, -1);

        for (int n = 0; n < 80; n++) begin
            op = int'($urandom_range(0, 9));
            a = 32'(pool[$urandom_range(0, 6)]) + 32'(4 * $urandom_range(0, 3));
            if (op <= 5) access(1'b0, a, 32'h0, int'($urandom_range(0, 2)), -1);
            else if (op <= 8) access(1'b1, a, $urandom, int'($urandom_range(0, 2)), -1);
            else inval_idle();
        end

`ifdef RV_CACHE_STATS_EN
        check("hit_cnt", hit_cnt, 32'(exp_hits));
        check("miss_cnt", miss_cnt, 32'(exp_misses));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
